// File: rtl/pool_sched_pkg.sv
// Shared definitions for the pool scheduler and the pool engine it drives:
// scheduler state encoding and default field widths.
package pool_sched_pkg;

   localparam int unsigned DefFrameWidth      = 8;
   localparam int unsigned DefPatchWidth      = 8;
   localparam int unsigned DefPoolKernelWidth = 3;
   localparam int unsigned CfgFlWidth         = 5;

   typedef enum logic [2:0] {
      StIdle,
      StWaitPel,
      StLaunch,
      StRun,
      StNext
   } pool_state_e;

endpackage

// File: rtl/pool_sched.sv
// Layer scheduler for the pool engine: launches one pool pass per finished PE-line
// patch, walks patch/frame counters and drives the frame-pool/delta controls.
module pool_sched
   import pool_sched_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH       = DefFrameWidth,
   parameter int unsigned PATCH_WIDTH       = DefPatchWidth,
   parameter int unsigned POOL_KERNEL_WIDTH = DefPoolKernelWidth
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      Start,
   input  logic [CfgFlWidth-1:0]                     CfgFl,
   input  logic                                      CfgPoolIfm,
   input  logic [POOL_KERNEL_WIDTH-1:0]              CfgStride,
   input  logic [PATCH_WIDTH-1:0]                    CfgNumPatch,
   input  logic [FRAME_WIDTH-1:0]                    CfgNumFrm,
   input  logic                                      PEL_Fnh,
   input  logic                                      POOL_Fnh,
   output logic                                      POOL_En,
   output logic [CfgFlWidth+POOL_KERNEL_WIDTH:0]     CFG_POOL,
   output logic                                      POOL_ValFrm,
   output logic                                      POOL_ValDelta,
   output logic                                      PEL_Rdy,
   output logic                                      Busy,
   output logic                                      Done,
   output logic                                      Err,
   output logic [FRAME_WIDTH-1:0]                    CntFrm,
   output logic [PATCH_WIDTH-1:0]                    CntPatch
);

   pool_state_e                  state_q, state_d;
   logic [CfgFlWidth-1:0]        cfg_fl_q;
   logic                         cfg_ifm_q;
   logic [POOL_KERNEL_WIDTH-1:0] cfg_stride_q;
   logic [PATCH_WIDTH-1:0]       num_patch_q;
   logic [FRAME_WIDTH-1:0]       num_frm_q;
   logic [FRAME_WIDTH-1:0]       cnt_frm_q, cnt_frm_d;
   logic [PATCH_WIDTH-1:0]       cnt_patch_q, cnt_patch_d;
   logic                         pend_q, pend_d;
   logic                         err_q, err_d;
   logic                         done_q, done_d;
   logic                         cfg_latch;
   logic                         cfg_legal;
   logic                         pel_in_flight;
   logic [FRAME_WIDTH-1:0]       out_frm;

   assign cfg_legal = ((CfgStride == POOL_KERNEL_WIDTH'(2)) ||
                       (CfgStride == POOL_KERNEL_WIDTH'(3))) &&
                      (CfgNumPatch != '0) && (CfgNumFrm != '0);

   // A PE-line finish while a patch is launching, pooling or retiring is queued one deep.
   assign pel_in_flight = PEL_Fnh &&
                          ((state_q == StLaunch) || (state_q == StRun) || (state_q == StNext));

   always_comb begin
      state_d     = state_q;
      cnt_frm_d   = cnt_frm_q;
      cnt_patch_d = cnt_patch_q;
      pend_d      = pend_q;
      err_d       = err_q;
      done_d      = 1'b0;
      cfg_latch   = 1'b0;

      if (pel_in_flight) begin
         if (pend_q) begin
            err_d = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (Start) begin
               if (cfg_legal) begin
                  cfg_latch   = 1'b1;
                  cnt_frm_d   = '0;
                  cnt_patch_d = '0;
                  pend_d      = 1'b0;
                  err_d       = 1'b0;
                  state_d     = StWaitPel;
               end else begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         StWaitPel: begin
            if (PEL_Fnh || pend_q) begin
               // A fresh finish arriving alongside a queued one stays queued.
               pend_d  = PEL_Fnh && pend_q;
               state_d = StLaunch;
            end
         end
         StLaunch: state_d = StRun;
         StRun: begin
            if (POOL_Fnh) begin
               state_d = StNext;
            end
         end
         StNext: begin
            state_d = StWaitPel;
            if (cnt_patch_q == num_patch_q - PATCH_WIDTH'(1)) begin
               cnt_patch_d = '0;
               cnt_frm_d   = cnt_frm_q + FRAME_WIDTH'(1);
               if (cnt_frm_q == num_frm_q - FRAME_WIDTH'(1)) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end else begin
               cnt_patch_d = cnt_patch_q + PATCH_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_frm_q   <= '0;
         cnt_patch_q <= '0;
         pend_q      <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_frm_q   <= cnt_frm_d;
         cnt_patch_q <= cnt_patch_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_fl_q     <= '0;
         cfg_ifm_q    <= 1'b0;
         cfg_stride_q <= '0;
         num_patch_q  <= '0;
         num_frm_q    <= '0;
      end else if (cfg_latch) begin
         cfg_fl_q     <= CfgFl;
         cfg_ifm_q    <= CfgPoolIfm;
         cfg_stride_q <= CfgStride;
         num_patch_q  <= CfgNumPatch;
         num_frm_q    <= CfgNumFrm;
      end
   end

   // Counters only move in StNext, so these stay fixed from launch through the pool run.
   assign out_frm       = cfg_ifm_q ? (cnt_frm_q >> 1) : cnt_frm_q;
   assign POOL_ValFrm   = cfg_ifm_q & cnt_frm_q[0];
   assign POOL_ValDelta = (out_frm != '0);

   assign POOL_En  = (state_q == StLaunch);
   assign PEL_Rdy  = (state_q == StWaitPel);
   assign Busy     = (state_q != StIdle);
   assign Done     = done_q;
   assign Err      = err_q;
   assign CFG_POOL = {cfg_fl_q, cfg_ifm_q, cfg_stride_q};
   assign CntFrm   = cnt_frm_q;
   assign CntPatch = cnt_patch_q;

endmodule

// File: tb/tb_pool_sched.sv
// Self-checking bench for pool_sched: directed layer scenarios with literal
// expectations, then randomized traffic against a behavioural layer model.
module tb_pool_sched;

   logic       clk;
   logic       rst_n;
   logic       Start;
   logic [4:0] CfgFl;
   logic       CfgPoolIfm;
   logic [2:0] CfgStride;
   logic [7:0] CfgNumPatch;
   logic [7:0] CfgNumFrm;
   logic       PEL_Fnh;
   logic       POOL_Fnh;
   logic       POOL_En;
   logic [8:0] CFG_POOL;
   logic       POOL_ValFrm;
   logic       POOL_ValDelta;
   logic       PEL_Rdy;
   logic       Busy;
   logic       Done;
   logic       Err;
   logic [7:0] CntFrm;
   logic [7:0] CntPatch;

   pool_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Start        (Start),
      .CfgFl        (CfgFl),
      .CfgPoolIfm   (CfgPoolIfm),
      .CfgStride    (CfgStride),
      .CfgNumPatch  (CfgNumPatch),
      .CfgNumFrm    (CfgNumFrm),
      .PEL_Fnh      (PEL_Fnh),
      .POOL_Fnh     (POOL_Fnh),
      .POOL_En      (POOL_En),
      .CFG_POOL     (CFG_POOL),
      .POOL_ValFrm  (POOL_ValFrm),
      .POOL_ValDelta(POOL_ValDelta),
      .PEL_Rdy      (PEL_Rdy),
      .Busy         (Busy),
      .Done         (Done),
      .Err          (Err),
      .CntFrm       (CntFrm),
      .CntPatch     (CntPatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int MIdle = 0, MWait = 1, MLaunch = 2, MRun = 3, MNext = 4;

   int checks = 0;
   int failures = 0;

   // Layer model: phase of the current patch, queued PE-line events, indices.
   int         m_phase;
   bit         m_pend, m_err, m_done;
   logic [4:0] m_fl;
   bit         m_ifm;
   logic [2:0] m_stride;
   int         m_np, m_nf, m_p;
   logic [7:0] m_f;

   int         en_cnt, done_cnt;
   logic [7:0] val_log;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = MIdle; m_pend = 0; m_err = 0; m_done = 0;
      m_fl = '0; m_ifm = 0; m_stride = '0; m_np = 0; m_nf = 0; m_p = 0; m_f = '0;
   endtask

   task automatic model_step();
      int  nphase;
      bit  ndone;
      bit  legal;
      nphase = m_phase;
      ndone  = 0;
      if (PEL_Fnh && (m_phase == MLaunch || m_phase == MRun || m_phase == MNext)) begin
         if (m_pend) m_err = 1;
         else m_pend = 1;
      end
      case (m_phase)
         MIdle: if (Start) begin
            legal = (CfgStride == 3'd2 || CfgStride == 3'd3) && CfgNumPatch != 0 && CfgNumFrm != 0;
            if (legal) begin
               m_fl = CfgFl; m_ifm = CfgPoolIfm; m_stride = CfgStride;
               m_np = int'(CfgNumPatch); m_nf = int'(CfgNumFrm);
               m_p = 0; m_f = '0; m_err = 0; m_pend = 0;
               nphase = MWait;
            end else begin
               m_err = 1; ndone = 1;
            end
         end
         MWait: if (PEL_Fnh || m_pend) begin
            m_pend = PEL_Fnh && m_pend;
            nphase = MLaunch;
         end
         MLaunch: nphase = MRun;
         MRun: if (POOL_Fnh) nphase = MNext;
         MNext: begin
            nphase = MWait;
            if (m_p == m_np - 1) begin
               m_p = 0;
               if (int'(m_f) + 1 == m_nf) begin
                  ndone = 1; nphase = MIdle;
               end
               m_f = m_f + 8'd1;
            end else begin
               m_p++;
            end
         end
         default: nphase = MIdle;
      endcase
      m_phase = nphase;
      m_done  = ndone;
   endtask

   task automatic compare();
      logic [7:0] ofrm;
      logic [8:0] exp_cfg;
      exp_cfg = {m_fl, m_ifm, m_stride};
      chk("busy", int'(Busy), int'(m_phase != MIdle));
      chk("pool_en", int'(POOL_En), int'(m_phase == MLaunch));
      chk("pel_rdy", int'(PEL_Rdy), int'(m_phase == MWait));
      chk("done", int'(Done), int'(m_done));
      chk("err", int'(Err), int'(m_err));
      chk("cfg_pool", int'(CFG_POOL), int'(exp_cfg));
      chk("cnt_frm", int'(CntFrm), int'(m_f));
      chk("cnt_patch", int'(CntPatch), m_p);
      if (m_phase == MLaunch || m_phase == MRun) begin
         ofrm = m_ifm ? (m_f >> 1) : m_f;
         chk("val_frm", int'(POOL_ValFrm), int'(m_ifm & m_f[0]));
         chk("val_delta", int'(POOL_ValDelta), int'(ofrm != 0));
      end
      if (POOL_En) begin
         en_cnt++;
         val_log = {val_log[5:0], POOL_ValFrm, POOL_ValDelta};
      end
      if (Done) done_cnt++;
   endtask

   task automatic step(input logic s, input logic pel, input logic pf);
      Start = s; PEL_Fnh = pel; POOL_Fnh = pf;
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      Start = 0; PEL_Fnh = 0; POOL_Fnh = 0;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare();
      chk("rst_val_frm", int'(POOL_ValFrm), 0);
      chk("rst_val_delta", int'(POOL_ValDelta), 0);
      @(negedge clk);
      compare();
      rst_n = 1'b1;
   endtask

   task automatic set_cfg(input logic [4:0] fl, input logic ifm, input logic [2:0] st,
                          input logic [7:0] np, input logic [7:0] nf);
      CfgFl = fl; CfgPoolIfm = ifm; CfgStride = st; CfgNumPatch = np; CfgNumFrm = nf;
   endtask

   // One patch from WAIT_PEL: PE-line finish, launch, pool run, pool finish, retire.
   task automatic patch();
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
   endtask

   logic [2:0] stride_tab [8] = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd7};

   initial begin
      rst_n = 1'b1;
      Start = 0; PEL_Fnh = 0; POOL_Fnh = 0;
      set_cfg(5'd0, 1'b0, 3'd2, 8'd1, 8'd1);
      en_cnt = 0; done_cnt = 0; val_log = '0;
      #2;
      do_reset();
      chk("lit_rst_cfg", int'(CFG_POOL), 0);
      chk("lit_rst_rdy", int'(PEL_Rdy), 0);

      // Two patches, one frame, no temporal pooling.
      set_cfg(5'd3, 1'b0, 3'd2, 8'd2, 8'd1);
      en_cnt = 0; done_cnt = 0; val_log = '0;
      step(1, 0, 0);
      chk("lit_busy_after_start", int'(Busy), 1);
      chk("lit_rdy_wait", int'(PEL_Rdy), 1);
      step(0, 1, 0);
      chk("lit_en_latency", int'(POOL_En), 1);
      chk("lit_rdy_launch", int'(PEL_Rdy), 0);
      step(0, 0, 0);
      chk("lit_en_one_cycle", int'(POOL_En), 0);
      chk("lit_rdy_run", int'(PEL_Rdy), 0);
      step(0, 0, 1);
      step(0, 0, 0);
      patch();
      chk("lit_two_launches", en_cnt, 2);
      chk("lit_one_done", done_cnt, 1);
      chk("lit_vals_zero", int'(val_log[3:0]), 0);
      chk("lit_idle_after", int'(Busy), 0);

      // Temporal pooling over four frames.
      set_cfg(5'd7, 1'b1, 3'd3, 8'd1, 8'd4);
      en_cnt = 0; done_cnt = 0; val_log = '0;
      step(1, 0, 0);
      chk("lit_cfg_pool", int'(CFG_POOL), int'(9'b00111_1_011));
      for (int i = 0; i < 4; i++) patch();
      chk("lit_val_seq", int'(val_log), int'(8'b00_10_01_11));
      chk("lit_ifm_done", done_cnt, 1);

      // Overrun: second PE-line finish during one run is dropped and flags Err.
      set_cfg(5'd1, 1'b0, 3'd2, 8'd2, 8'd1);
      en_cnt = 0; done_cnt = 0;
      step(1, 0, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      chk("lit_no_err_yet", int'(Err), 0);
      step(0, 1, 0);
      chk("lit_overrun_err", int'(Err), 1);
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("lit_pending_launch", int'(POOL_En), 1);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      chk("lit_overrun_launches", en_cnt, 2);
      chk("lit_overrun_done", done_cnt, 1);
      chk("lit_err_sticky", int'(Err), 1);

      // Illegal stride.
      set_cfg(5'd2, 1'b0, 3'd4, 8'd2, 8'd2);
      en_cnt = 0; done_cnt = 0;
      step(1, 0, 0);
      chk("lit_bad_err", int'(Err), 1);
      chk("lit_bad_done", int'(Done), 1);
      chk("lit_bad_busy", int'(Busy), 0);
      step(0, 1, 0);
      step(0, 0, 0);
      chk("lit_bad_no_en", en_cnt, 0);
      chk("lit_bad_done_pulse", int'(Done), 0);

      // Start while busy is ignored; reset mid-run abandons the layer.
      set_cfg(5'd3, 1'b0, 3'd2, 8'd2, 8'd2);
      done_cnt = 0;
      step(1, 0, 0);
      chk("lit_err_cleared", int'(Err), 0);
      set_cfg(5'd31, 1'b1, 3'd3, 8'd9, 8'd9);
      step(1, 0, 0);
      chk("lit_busy_start_cfg", int'(CFG_POOL), int'(9'b00011_0_010));
      step(0, 1, 0);
      step(0, 0, 0);
      do_reset();
      chk("lit_rst_busy", int'(Busy), 0);
      chk("lit_rst_en", int'(POOL_En), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      chk("lit_rst_no_done", done_cnt, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         logic s;
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            s = (m_phase == MIdle) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            if (s) begin
               set_cfg(5'($urandom), 1'($urandom),
                       stride_tab[$urandom_range(0, 7)],
                       ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 3)),
                       ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 5)));
            end
            step(s, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
